// File: rtl/zero_xing_monitor.sv
// Per-channel audio zero-crossing checker: measures samples/period and peak, counts out-of-window results.
// Optional ZXM_P2P_EN: peak becomes peak-to-peak (max - min since last crossing) instead of positive max.
module zero_xing_monitor #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 16,
    parameter int CNT_W      = 12,
    parameter int ERR_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SKIP_XINGS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      smp_vld,
    input  logic [NUM_CH*WIDTH-1:0]   smp,
    input  logic [WIN_W-1:0]          num_samples,
    input  logic [CNT_W-1:0]          min_cnt,
    input  logic [CNT_W-1:0]          max_cnt,
    input  logic [WIDTH:0]            min_ampl,
    input  logic [WIDTH:0]            max_ampl,
    output logic                      busy,
    output logic [NUM_CH-1:0]         done,
    output logic [NUM_CH-1:0]         meas_vld,
    output logic [NUM_CH*CNT_W-1:0]   meas_period,
    output logic [NUM_CH*(WIDTH+1)-1:0] meas_peak,
    output logic [NUM_CH*ERR_W-1:0]   freq_err,
    output logic [NUM_CH*ERR_W-1:0]   ampl_err
);
    localparam int XW = $clog2(SKIP_XINGS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_TEST, ST_DONE} state_t;

    logic [NUM_CH-1:0] busy_ch;

    assign busy = |busy_ch;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t                   state_q, state_n;
        logic signed [WIDTH-1:0]  s;
        logic                     prev_sign_q, xing, chk, last;
        logic [CNT_W-1:0]         cnt_q, cnt_inc, period_q;
        logic signed [WIDTH-1:0]  max_q, max_n;
        logic [WIDTH:0]           peak_n, peak_q;
        logic [XW-1:0]            xcnt_q;
        logic [WIN_W-1:0]         win_q;
        logic [WIN_W:0]           win_inc;
        logic [ERR_W-1:0]         ferr_q, aerr_q;
        logic                     vld_q;

        assign s       = smp[c*WIDTH +: WIDTH];
        assign xing    = smp_vld && prev_sign_q && !s[WIDTH-1];
        assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        assign max_n   = (s > max_q) ? s : max_q;
`ifdef ZXM_P2P_EN
        logic signed [WIDTH-1:0] min_q, min_n;
        assign min_n  = (s < min_q) ? s : min_q;
        // max >= 0 and min <= 0, so the difference always fits WIDTH+1 unsigned bits
        assign peak_n = {max_n[WIDTH-1], max_n} - {min_n[WIDTH-1], min_n};
`else
        assign peak_n = {1'b0, max_n};
`endif
        assign win_inc = {1'b0, win_q} + 1'b1;
        assign last    = (win_inc >= {1'b0, num_samples});
        // an empty window never checks anything
        assign chk     = !start && (state_q == ST_TEST) && xing && (num_samples != '0);

        always_comb begin
            state_n = state_q;
            if (start) begin
                state_n = ST_SKIP;
            end else if (smp_vld) begin
                case (state_q)
                    ST_SKIP: if (xing && xcnt_q == XW'(SKIP_XINGS - 1)) state_n = ST_TEST;
                    ST_TEST: if (last) state_n = ST_DONE;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) state_q <= ST_IDLE;
            else     state_q <= state_n;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev_sign_q <= 1'b0;
                cnt_q       <= '0;
                max_q       <= '0;
`ifdef ZXM_P2P_EN
                min_q       <= '0;
`endif
                xcnt_q      <= '0;
                win_q       <= '0;
                ferr_q      <= '0;
                aerr_q      <= '0;
                period_q    <= '0;
                peak_q      <= '0;
                vld_q       <= 1'b0;
            end else begin
                vld_q <= 1'b0;
                if (start) begin
                    cnt_q  <= '0;
                    max_q  <= '0;
`ifdef ZXM_P2P_EN
                    min_q  <= '0;
`endif
                    xcnt_q <= '0;
                    win_q  <= '0;
                    ferr_q <= '0;
                    aerr_q <= '0;
                end else if (smp_vld) begin
                    prev_sign_q <= s[WIDTH-1];
                    // the crossing sample belongs to the period it closes
                    if (xing) begin
                        cnt_q <= '0;
                        max_q <= '0;
`ifdef ZXM_P2P_EN
                        min_q <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_inc;
                        max_q <= max_n;
`ifdef ZXM_P2P_EN
                        min_q <= min_n;
`endif
                    end
                    if (state_q == ST_SKIP && xing) xcnt_q <= xcnt_q + 1'b1;
                    if (state_q == ST_TEST) win_q <= win_inc[WIN_W-1:0];
                    if (chk) begin
                        vld_q    <= 1'b1;
                        period_q <= cnt_inc;
                        peak_q   <= peak_n;
                        if ((cnt_inc < min_cnt || cnt_inc > max_cnt) && !(&ferr_q))
                            ferr_q <= ferr_q + 1'b1;
                        if ((peak_n < min_ampl || peak_n > max_ampl) && !(&aerr_q))
                            aerr_q <= aerr_q + 1'b1;
                    end
                end
            end
        end

        assign busy_ch[c]                          = (state_q == ST_SKIP) || (state_q == ST_TEST);
        assign done[c]                             = (state_q == ST_DONE);
        assign meas_vld[c]                         = vld_q;
        assign meas_period[c*CNT_W +: CNT_W]       = period_q;
        assign meas_peak[c*(WIDTH+1) +: WIDTH+1]   = peak_q;
        assign freq_err[c*ERR_W +: ERR_W]          = ferr_q;
        assign ampl_err[c*ERR_W +: ERR_W]          = aerr_q;
    end

endmodule
